// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - multi-cycle processor control unit (FETCH/DECODE/EXEC/MEM/WB)
module multicycle_seq #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [3:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic [2:0]  State,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] count_q, count_d;

  logic [7:0]  wait_inc;
  logic        wait_expired;

  logic        pc_write, ir_write, reg_dst, branch;
  logic        mem_read, mem_write, reg_write, mem_to_reg, alu_src;
  logic [1:0]  alu_op;

  // The current memory wait cycle is the one that makes the counter reach the limit.
  assign wait_inc     = wait_q + 8'd1;
  assign wait_expired = (wait_inc == WAIT_LIMIT);

  // State, captured opcode, wait counter and instruction count registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
      wait_q  <= 8'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state and control decode; the wait counter is zero unless we stay waiting.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = 8'd0;
    count_d    = count_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          count_d  = count_q + 16'd1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_HALT:                                       state_d = S_HALT;
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
          default:                                       state_d = S_FETCH;
        endcase
      end

      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'b01;
            branch   = 1'b1;
            pc_write = Zero;
            state_d  = S_FETCH;
          end
          OP_BNE: begin
            alu_op   = 2'b01;
            branch   = 1'b1;
            pc_write = ~Zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
        end else if (op_q == OP_SW) begin
          mem_write = 1'b1;
        end
        if (op_q != OP_LW && op_q != OP_SW) begin
          state_d = S_FETCH;
        end else if (MemReady) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Reset forces every output low immediately, independent of the clock.
  assign PCWrite    = Resetn & pc_write;
  assign IRWrite    = Resetn & ir_write;
  assign RegDst     = Resetn & reg_dst;
  assign Branch     = Resetn & branch;
  assign MemRead    = Resetn & mem_read;
  assign MemWrite   = Resetn & mem_write;
  assign RegWrite   = Resetn & reg_write;
  assign MemToReg   = Resetn & mem_to_reg;
  assign ALUSrc     = Resetn & alu_src;
  assign ALUOp      = Resetn ? alu_op : 2'b00;
  assign State      = Resetn ? 3'(state_q) : 3'd0;
  assign Halted     = Resetn & (state_q == S_HALT);
  assign Fault      = Resetn & (state_q == S_FAULT);
  assign InstrCount = Resetn ? count_q : 16'd0;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - self-checking bench for multicycle_seq
module tb_multicycle_seq;

  logic        clk;
  logic        rstn;
  logic [3:0]  op;
  logic        zero;
  logic        rdy;
  logic        PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite;
  logic        RegWrite, MemToReg, ALUSrc, Halted, Fault;
  logic [1:0]  ALUOp;
  logic [2:0]  State;
  logic [15:0] InstrCount;

  multicycle_seq #(.WAIT_MAX(15)) dut (
    .Clock(clk), .Resetn(rstn), .Opcode(op), .Zero(zero), .MemReady(rdy),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .State(State),
    .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] PCW  = 11'h400;
  localparam logic [10:0] IRW  = 11'h200;
  localparam logic [10:0] RDST = 11'h100;
  localparam logic [10:0] BR   = 11'h080;
  localparam logic [10:0] MRD  = 11'h040;
  localparam logic [10:0] MWR  = 11'h020;
  localparam logic [10:0] RWR  = 11'h010;
  localparam logic [10:0] M2R  = 11'h008;
  localparam logic [10:0] ASRC = 11'h004;
  localparam logic [10:0] AFN  = 11'h002;
  localparam logic [10:0] ASUB = 11'h001;
  localparam logic [10:0] NONE = 11'h000;
  localparam logic [10:0] FET  = PCW | IRW | MRD;

  typedef struct {
    logic        rstn;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [10:0] ctl;
    logic [2:0]  st;
    logic        hl;
    logic        flt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  logic [10:0] ctl_act;
  assign ctl_act = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite,
                    RegWrite, MemToReg, ALUSrc, ALUOp};

  task automatic add(input logic r, input logic [3:0] o, input logic z, input logic m,
                     input logic [10:0] c, input logic [2:0] s, input logic h,
                     input logic f, input logic [15:0] n);
    vec_t v;
    v.rstn = r; v.op = o; v.z = z; v.rdy = m;
    v.ctl = c; v.st = s; v.hl = h; v.flt = f; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, mid-cycle.
  task automatic apply(input logic r, input logic [3:0] o, input logic z, input logic m);
    @(negedge clk);
    rstn = r; op = o; zero = z; rdy = m;
    #1;
  endtask

  initial begin
    rstn = 1'b0; op = 4'd0; zero = 1'b0; rdy = 1'b0;

    add(0, 4'h0, 0, 1, NONE, 0, 0, 0, 0);
    // R-type
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 0);
    add(1, 4'h0, 0, 0, NONE,       1, 0, 0, 1);
    add(1, 4'hF, 0, 0, AFN,        2, 0, 0, 1);
    add(1, 4'hF, 0, 0, RWR | RDST, 4, 0, 0, 1);
    add(1, 4'h0, 0, 0, MRD,        0, 0, 0, 1);
    // ADDI, MemReady in EXEC ignored
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 1);
    add(1, 4'h1, 0, 0, NONE,       1, 0, 0, 2);
    add(1, 4'h1, 0, 1, ASRC,       2, 0, 0, 2);
    add(1, 4'h0, 0, 0, RWR,        4, 0, 0, 2);
    // LW with 3 wait cycles in MEM
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 2);
    add(1, 4'h2, 0, 0, NONE,       1, 0, 0, 3);
    add(1, 4'h2, 0, 0, ASRC,       2, 0, 0, 3);
    add(1, 4'h2, 0, 0, MRD,        3, 0, 0, 3);
    add(1, 4'h2, 0, 0, MRD,        3, 0, 0, 3);
    add(1, 4'h2, 0, 0, MRD,        3, 0, 0, 3);
    add(1, 4'h2, 0, 1, MRD,        3, 0, 0, 3);
    add(1, 4'h2, 0, 0, RWR | M2R,  4, 0, 0, 3);
    // SW
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 3);
    add(1, 4'h3, 0, 0, NONE,       1, 0, 0, 4);
    add(1, 4'h3, 0, 0, ASRC,       2, 0, 0, 4);
    add(1, 4'h3, 0, 0, MWR,        3, 0, 0, 4);
    add(1, 4'h3, 0, 1, MWR,        3, 0, 0, 4);
    // BEQ Z=1, BNE Z=1, BNE Z=0, BEQ Z=0
    add(1, 4'h0, 0, 1, FET,             0, 0, 0, 4);
    add(1, 4'h4, 0, 0, NONE,            1, 0, 0, 5);
    add(1, 4'h4, 1, 0, BR | PCW | ASUB, 2, 0, 0, 5);
    add(1, 4'h0, 0, 1, FET,             0, 0, 0, 5);
    add(1, 4'h5, 0, 0, NONE,            1, 0, 0, 6);
    add(1, 4'h5, 1, 0, BR | ASUB,       2, 0, 0, 6);
    add(1, 4'h0, 0, 1, FET,             0, 0, 0, 6);
    add(1, 4'h5, 0, 0, NONE,            1, 0, 0, 7);
    add(1, 4'h5, 0, 0, BR | PCW | ASUB, 2, 0, 0, 7);
    add(1, 4'h0, 0, 1, FET,             0, 0, 0, 7);
    add(1, 4'h4, 0, 0, NONE,            1, 0, 0, 8);
    add(1, 4'h4, 0, 0, BR | ASUB,       2, 0, 0, 8);
    // illegal opcode 1010 acts as a NOP
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 8);
    add(1, 4'hA, 0, 0, NONE,       1, 0, 0, 9);
    add(1, 4'h0, 0, 0, MRD,        0, 0, 0, 9);
    // HALT is absorbing, MemReady ignored
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 9);
    add(1, 4'hF, 0, 0, NONE,       1, 0, 0, 10);
    add(1, 4'h0, 0, 1, NONE,       5, 1, 0, 10);
    add(1, 4'h0, 0, 1, NONE,       5, 1, 0, 10);
    add(0, 4'h0, 0, 1, NONE,       0, 0, 0, 0);
    // reset during SW MEM
    add(1, 4'h0, 0, 1, FET,        0, 0, 0, 0);
    add(1, 4'h3, 0, 0, NONE,       1, 0, 0, 1);
    add(1, 4'h3, 0, 0, ASRC,       2, 0, 0, 1);
    add(1, 4'h3, 0, 0, MWR,        3, 0, 0, 1);
    add(0, 4'h3, 0, 0, NONE,       0, 0, 0, 0);
    add(1, 4'h3, 0, 0, MRD,        0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rstn, vecs[i].op, vecs[i].z, vecs[i].rdy);
      chk($sformatf("row%0d", i),
          {ctl_act, State, Halted, Fault, InstrCount},
          {vecs[i].ctl, vecs[i].st, vecs[i].hl, vecs[i].flt, vecs[i].cnt});
    end

    // FETCH timeout: 15 wait cycles, then FAULT until reset
    apply(0, 4'h0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      apply(1, 4'h0, 0, 0);
      chk($sformatf("fetch_wait%0d", i), {29'd0, State}, {29'd0, 3'd0});
    end
    apply(1, 4'h0, 0, 1);
    chk("fault_entry", {24'd0, State, Fault, MemRead, IRWrite, PCWrite, Halted},
        {24'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    apply(1, 4'h0, 0, 0);
    chk("fault_hold", {28'd0, State, Fault}, {28'd0, 3'd6, 1'b1});
    apply(0, 4'h0, 0, 0);
    chk("fault_reset", {28'd0, State, Fault}, {28'd0, 3'd0, 1'b0});

    // MemReady on the final allowed wait cycle completes the fetch
    for (int i = 0; i < 14; i++) apply(1, 4'h0, 0, 0);
    apply(1, 4'h0, 0, 1);
    chk("ready_wins", {28'd0, State, PCWrite}, {28'd0, 3'd0, 1'b1});
    apply(1, 4'hA, 0, 0);
    chk("ready_wins_decode", {13'd0, State, InstrCount}, {13'd0, 3'd1, 16'd1});
    // Wait counter restarts on re-entry to FETCH: full 15 cycles again
    for (int i = 0; i < 15; i++) apply(1, 4'h0, 0, 0);
    chk("refetch_wait", {28'd0, State, Fault}, {28'd0, 3'd0, 1'b0});
    apply(1, 4'h0, 0, 0);
    chk("refetch_fault", {28'd0, State, Fault}, {28'd0, 3'd6, 1'b1});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum number of consecutive cycles spent waiting on MemReady before a fault (range 1..255).
REQ-002 Clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 Opcode  input  4  instruction opcode from the datapath instruction register.
REQ-005 Zero  input  1  ALU zero flag from the datapath.
REQ-006 MemReady  input  1  memory completion strobe for the current read or write.
REQ-007 PCWrite, IRWrite  output  1 each  PC load enable and instruction-register load enable.
REQ-008 RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc  output  1 each  datapath controls, same meanings as the single-cycle CU.
REQ-009 ALUOp  output  2  00 add, 01 subtract, 10 function-field decode, 11 unused.
REQ-010 State  output  3  current state encoding.
REQ-011 Halted, Fault  output  1 each  state == HALT, state == FAULT.
REQ-012 InstrCount  output  16  count of completed instruction fetches.

Function
REQ-013 The block SHALL implement these states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 SHALL transition to FAULT.
REQ-014 Opcode classes SHALL be: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 BNE, 1111 HALT; all other opcodes are illegal and execute as a NOP.
REQ-015 Opcode SHALL be captured into an internal register on the DECODE cycle only; EXEC, MEM and WB controls SHALL decode from that register, never from the live Opcode.
REQ-016 Every output not listed for a state SHALL be 0 in that state.
REQ-017 FETCH: MemRead=1; while MemReady=0 the block SHALL stay in FETCH; on MemReady=1 it SHALL assert IRWrite=1 and PCWrite=1 in that same cycle (Mealy), increment InstrCount (modulo 2^16), and go to DECODE.
REQ-018 DECODE: HALT goes to HALT; an illegal opcode goes to FETCH; every other opcode goes to EXEC.
REQ-019 EXEC for R-type: ALUSrc=0, ALUOp=10; next state WB.
REQ-020 EXEC for ADDI: ALUSrc=1, ALUOp=00; next state WB.
REQ-021 EXEC for LW and SW: ALUSrc=1, ALUOp=00; next state MEM.
REQ-022 EXEC for BEQ/BNE: ALUSrc=0, ALUOp=01, Branch=1; PCWrite=1 when Zero=1 for BEQ or Zero=0 for BNE; next state FETCH.
REQ-023 MEM for LW: MemRead=1 until MemReady, then go to WB.
REQ-024 MEM for SW: MemWrite=1 until MemReady, then go to FETCH.
REQ-025 WB: RegWrite=1; RegDst=1 only for R-type; MemToReg=1 only for LW; next state FETCH.
REQ-026 A wait counter SHALL clear on every entry to FETCH or MEM and on MemReady=1, and SHALL increment each cycle spent in FETCH or MEM with MemReady=0.
REQ-027 When the wait counter reaches WAIT_MAX with MemReady still 0, the next state SHALL be FAULT; if MemReady=1 arrives on that same cycle, completion wins.
REQ-028 HALT and FAULT SHALL be absorbing: all controls are 0, and only reset exits them.
REQ-029 MemRead and MemWrite SHALL never be asserted together; PCWrite SHALL be asserted at most once per instruction when not branching, and at most twice per instruction when a branch is taken.
REQ-030 MemReady asserted outside FETCH or MEM SHALL be ignored.

Reset
REQ-031 While Resetn=0: state=FETCH, opcode register=0, wait counter=0, InstrCount=0, and all outputs are forced to 0 combinationally (MemRead included).
REQ-032 Reset asserted mid-instruction (for example in MEM during SW) SHALL deassert MemWrite immediately, with no partial completion; after reset release the block SHALL start in FETCH on the first rising edge.

Verification
REQ-033 R-type: Opcode=0000, MemReady=1 on the first FETCH cycle -> states 0,1,2,4,0; WB has RegWrite=1, RegDst=1; InstrCount=1.
REQ-034 LW with a 3-cycle memory wait in MEM -> MemRead held for 4 MEM cycles, then WB with MemToReg=1, RegWrite=1; total 8 cycles.
REQ-035 BEQ with Zero=1 -> EXEC shows Branch=1, ALUOp=01, PCWrite=1; BNE with Zero=1 -> PCWrite=0 in EXEC.
REQ-036 WAIT_MAX=15, MemReady held at 0 in FETCH -> FAULT entered after 15 wait cycles; Fault=1; state persists until Resetn pulses low.
REQ-037 Opcode=1111 -> Halted=1 after DECODE and InstrCount frozen; opcode 1010 -> NOP back to FETCH, InstrCount still increments.
REQ-038 Resetn pulled low during MEM for SW -> MemWrite=0 in the same cycle; State=0 and InstrCount=0.
